// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the five pipeline registers of a classic
//   5-stage integer pipe (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
//   - Load-use hazards insert a single bubble into ID_EX.
//   - Taken branches squash the two younger instructions (IF_ID and ID_EX).
//   - Multi-cycle mult/div holds the front of the pipe while bubbles drain
//     out behind it.
//   - Data-memory waits freeze the whole pipe.
//   A saturating count of frozen-PC cycles and a sticky memory-timeout flag
//   are kept for debug/performance visibility.
//
// Parameters
//   MD_LATENCY   cycles a mult/div holds EX, counted from its acceptance (>=2)
//   MEM_TIMEOUT  memory-wait cycles before MEM_Timeout sets (>=1)
//   CNT_W        width of StallCount
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   synchronous, active-low
//   ID_RS, ID_RT    in   [4:0] source registers of the instruction in ID
//   ID_UsesRS/RT    in   ID instruction actually reads RS / RT
//   EX_RD           in   [4:0] destination register of the instruction in EX
//   EX_MemRead      in   EX instruction is a load
//   EX_MDStart      in   EX instruction is a mult/div
//   EX_BranchTaken  in   branch/jump resolved taken in EX
//   MEM_Access      in   load/store in MEM this cycle
//   MEM_Ready       in   data memory completes the access this cycle
//   *_En            out  1 = pipeline register loads
//   *_Flush         out  1 = pipeline register loads a bubble (En is 1 too)
//   MD_Busy         out  mult/div sequencing in progress
//   MEM_Timeout     out  sticky, cleared only by reset
//   StallCount      out  [CNT_W-1:0] cycles with PC_En==0, saturating
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_UsesRS,
  input  logic             ID_UsesRT,
  input  logic [4:0]       EX_RD,
  input  logic             EX_MemRead,
  input  logic             EX_MDStart,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Access,
  input  logic             MEM_Ready,
  output logic             PC_En,
  output logic             IF_ID_En,
  output logic             ID_EX_En,
  output logic             EX_MEM_En,
  output logic             MEM_WB_En,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             MD_Busy,
  output logic             MEM_Timeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MDC_W = (MD_LATENCY  > 2) ? $clog2(MD_LATENCY)    : 1;
  localparam int WC_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT+1) : 1;

  localparam logic [MDC_W-1:0] MD_LOAD  = MDC_W'(MD_LATENCY - 1);
  localparam logic [WC_W-1:0]  WAIT_MAX = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0]  WAIT_ONE = WC_W'(1);
  localparam logic [MDC_W-1:0] MD_ONE   = MDC_W'(1);

  // Enable vector order: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
  localparam logic [4:0] EN_ALL    = 5'b11111;
  localparam logic [4:0] EN_NONE   = 5'b00000;
  localparam logic [4:0] EN_MDHOLD = 5'b00011;
  localparam logic [4:0] EN_LDUSE  = 5'b00111;
  // Flush vector order: {IF_ID, ID_EX, EX_MEM}
  localparam logic [2:0] FL_NONE   = 3'b000;
  localparam logic [2:0] FL_MDHOLD = 3'b001;
  localparam logic [2:0] FL_LDUSE  = 3'b010;
  localparam logic [2:0] FL_BRANCH = 3'b110;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MD_BUSY  = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MDC_W-1:0]   r_md_cnt;
  logic [MDC_W-1:0]   w_md_cnt_nxt;
  logic [WC_W-1:0]    r_wait_cnt;
  logic [WC_W-1:0]    w_wait_cnt_nxt;
  logic               r_timeout;
  logic               w_timeout_set;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_memstall;
  logic               w_loaduse;
  logic               w_rs_hit;
  logic               w_rt_hit;

  // RUN-state decode, shared with the MEM_WAIT release cycle
  logic [4:0]         w_run_en;
  logic [2:0]         w_run_fl;
  state_t             w_run_next;
  logic               w_run_md_load;
  logic               w_run_wait_start;

  logic [4:0]         w_en;
  logic [2:0]         w_fl;

  assign w_memstall = MEM_Access & ~MEM_Ready;
  assign w_rs_hit   = ID_UsesRS & (ID_RS == EX_RD);
  assign w_rt_hit   = ID_UsesRT & (ID_RT == EX_RD);
  // $0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign w_loaduse  = EX_MemRead & (EX_RD != 5'd0) & (w_rs_hit | w_rt_hit);

  always_comb begin
    w_run_en         = EN_ALL;
    w_run_fl         = FL_NONE;
    w_run_next       = S_RUN;
    w_run_md_load    = 1'b0;
    w_run_wait_start = 1'b0;
    if (w_memstall) begin
      w_run_en         = EN_NONE;
      w_run_next       = S_MEM_WAIT;
      w_run_wait_start = 1'b1;
    end else if (EX_MDStart) begin
      // Hold the mult/div in EX; the bubble behind it lets MEM/WB drain.
      w_run_en      = EN_MDHOLD;
      w_run_fl      = FL_MDHOLD;
      w_run_md_load = 1'b1;
      w_run_next    = S_MD_BUSY;
    end else if (EX_BranchTaken) begin
      // Branch wins over load-use: the dependent instruction is squashed anyway.
      w_run_fl = FL_BRANCH;
    end else if (w_loaduse) begin
      w_run_en = EN_LDUSE;
      w_run_fl = FL_LDUSE;
    end
  end

  always_comb begin
    w_en           = EN_NONE;
    w_fl           = FL_NONE;
    w_state_nxt    = r_state;
    w_md_cnt_nxt   = r_md_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_set  = 1'b0;

    case (r_state)
      S_RUN: begin
        w_en        = w_run_en;
        w_fl        = w_run_fl;
        w_state_nxt = w_run_next;
        if (w_run_md_load)    w_md_cnt_nxt   = MD_LOAD;
        if (w_run_wait_start) w_wait_cnt_nxt = WAIT_ONE;
      end

      S_MD_BUSY: begin
        // The mult/div unit keeps counting even while memory stalls.
        if (r_md_cnt != '0) begin
          w_md_cnt_nxt = r_md_cnt - MD_ONE;
          if (!w_memstall) begin
            w_en = EN_MDHOLD;
            w_fl = FL_MDHOLD;
          end
        end else if (!w_memstall) begin
          w_en        = EN_ALL;
          w_state_nxt = S_RUN;
        end
      end

      S_MEM_WAIT: begin
        if (MEM_Ready) begin
          // memstall is necessarily 0 here, so RUN decode resumes directly.
          w_en           = w_run_en;
          w_fl           = w_run_fl;
          w_state_nxt    = w_run_next;
          w_wait_cnt_nxt = '0;
          if (w_run_md_load) w_md_cnt_nxt = MD_LOAD;
        end else if (r_wait_cnt == WAIT_MAX) begin
          w_timeout_set = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
        end
      end

      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    if (!reset) begin
      w_en = EN_NONE;
      w_fl = FL_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_md_cnt    <= '0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_cnt   <= w_md_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_set) r_timeout <= 1'b1;
      if (!w_en[4] && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign PC_En        = w_en[4];
  assign IF_ID_En     = w_en[3];
  assign ID_EX_En     = w_en[2];
  assign EX_MEM_En    = w_en[1];
  assign MEM_WB_En    = w_en[0];
  assign IF_ID_Flush  = w_fl[2];
  assign ID_EX_Flush  = w_fl[1];
  assign EX_MEM_Flush = w_fl[0];
  assign MD_Busy      = reset & (r_state == S_MD_BUSY);
  assign MEM_Timeout  = r_timeout;
  assign StallCount   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ID_RS, ID_RT, EX_RD;
  logic        ID_UsesRS, ID_UsesRT, EX_MemRead, EX_MDStart, EX_BranchTaken;
  logic        MEM_Access, MEM_Ready;
  logic        PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En;
  logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MD_Busy, MEM_Timeout;
  logic [15:0] StallCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .MEM_TIMEOUT(5), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_UsesRS(ID_UsesRS), .ID_UsesRT(ID_UsesRT),
    .EX_RD(EX_RD), .EX_MemRead(EX_MemRead), .EX_MDStart(EX_MDStart),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Access(MEM_Access), .MEM_Ready(MEM_Ready),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .ID_EX_En(ID_EX_En), .EX_MEM_En(EX_MEM_En),
    .MEM_WB_En(MEM_WB_En), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Flush(EX_MEM_Flush), .MD_Busy(MD_Busy), .MEM_Timeout(MEM_Timeout),
    .StallCount(StallCount)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, memrd, br, acc, rdy;
    logic [4:0] en;
    logic [2:0] fl;
  } vec_t;

  vec_t vt[10];

  function automatic logic [4:0] en_v();
    return {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En};
  endfunction

  function automatic logic [2:0] fl_v();
    return {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ID_RS = 5'd1; ID_RT = 5'd2; ID_UsesRS = 1'b1; ID_UsesRT = 1'b1;
    EX_RD = 5'd3; EX_MemRead = 1'b0; EX_MDStart = 1'b0; EX_BranchTaken = 1'b0;
    MEM_Access = 1'b0; MEM_Ready = 1'b0;
  endtask

  task automatic set_loaduse();
    ID_RS = 5'd5; ID_UsesRS = 1'b1; EX_RD = 5'd5; EX_MemRead = 1'b1;
  endtask

  // Inputs change on the falling edge; outputs are checked 2 time units later.
  task automatic next_cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    next_cyc(); reset = 1'b0; idle();
    next_cyc();
    next_cyc(); reset = 1'b1;
  endtask

  initial begin
    int exp_stalls;

    vt[0] = '{"idle",      5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0, 0, 5'b11111, 3'b000};
    vt[1] = '{"lu_rs",     5'd5, 5'd2, 5'd5, 1, 1, 1, 0, 0, 0, 5'b00111, 3'b010};
    vt[2] = '{"lu_rt",     5'd1, 5'd7, 5'd7, 1, 1, 1, 0, 0, 0, 5'b00111, 3'b010};
    vt[3] = '{"rd_zero",   5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 5'b11111, 3'b000};
    vt[4] = '{"no_uses",   5'd5, 5'd5, 5'd5, 0, 0, 1, 0, 0, 0, 5'b11111, 3'b000};
    vt[5] = '{"branch",    5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0, 0, 5'b11111, 3'b110};
    vt[6] = '{"br_lu",     5'd5, 5'd2, 5'd5, 1, 1, 1, 1, 0, 0, 5'b11111, 3'b110};
    vt[7] = '{"not_load",  5'd5, 5'd2, 5'd5, 1, 1, 0, 0, 0, 0, 5'b11111, 3'b000};
    vt[8] = '{"mem_rdy",   5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 1, 1, 5'b11111, 3'b000};
    vt[9] = '{"rt_unused", 5'd1, 5'd5, 5'd5, 1, 0, 1, 0, 0, 0, 5'b11111, 3'b000};

    // ---- reset state ----
    reset = 1'b0;
    idle();
    set_loaduse();
    EX_BranchTaken = 1'b1;
    next_cyc(); #2;
    chk("rst_en", 32'(en_v()), 32'h0);
    chk("rst_fl", 32'(fl_v()), 32'h0);
    chk("rst_mdbusy", 32'(MD_Busy), 32'h0);
    next_cyc(); #2;
    chk("rst_stallcnt", 32'(StallCount), 32'h0);
    chk("rst_timeout", 32'(MEM_Timeout), 32'h0);
    next_cyc(); reset = 1'b1; idle(); #2;
    chk("idle_en", 32'(en_v()), 32'h1F);

    // ---- table-driven single-cycle RUN decode ----
    exp_stalls = 0;
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      idle();
      ID_RS = vt[i].rs; ID_RT = vt[i].rt; EX_RD = vt[i].rd;
      ID_UsesRS = vt[i].urs; ID_UsesRT = vt[i].urt; EX_MemRead = vt[i].memrd;
      EX_BranchTaken = vt[i].br; MEM_Access = vt[i].acc; MEM_Ready = vt[i].rdy;
      #2;
      chk({vt[i].name, "_en"}, 32'(en_v()), 32'(vt[i].en));
      chk({vt[i].name, "_fl"}, 32'(fl_v()), 32'(vt[i].fl));
      if (!vt[i].en[4]) exp_stalls++;
    end
    next_cyc(); idle(); #2;
    chk("table_stallcnt", 32'(StallCount), 32'(exp_stalls));

    // ---- load-use stalls exactly one cycle ----
    do_reset();
    set_loaduse(); #2;
    chk("lu1_en", 32'(en_v()), 32'h07);
    next_cyc(); idle(); #2;
    chk("lu1_after_en", 32'(en_v()), 32'h1F);
    chk("lu1_stallcnt", 32'(StallCount), 32'd1);

    // ---- mult/div, latency 4 ----
    do_reset();
    EX_MDStart = 1'b1; #2;
    chk("md0_en", 32'(en_v()), 32'h03);
    chk("md0_fl", 32'(fl_v()), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      next_cyc(); #2;   // EX_MDStart still high: must be ignored while busy
      chk($sformatf("md%0d_en", c), 32'(en_v()), 32'h03);
      chk($sformatf("md%0d_fl", c), 32'(fl_v()), 32'h1);
      chk($sformatf("md%0d_busy", c), 32'(MD_Busy), 32'h1);
    end
    next_cyc(); EX_MDStart = 1'b0; #2;
    chk("md_rel_en", 32'(en_v()), 32'h1F);
    chk("md_rel_fl", 32'(fl_v()), 32'h0);
    next_cyc(); #2;
    chk("md_done_busy", 32'(MD_Busy), 32'h0);
    chk("md_done_en", 32'(en_v()), 32'h1F);
    chk("md_stallcnt", 32'(StallCount), 32'd4);

    // ---- mult/div with memory stalls: counter keeps running ----
    do_reset();
    EX_MDStart = 1'b1; #2;
    chk("mdm0_en", 32'(en_v()), 32'h03);
    next_cyc(); EX_MDStart = 1'b0; MEM_Access = 1'b1; MEM_Ready = 1'b0; #2;
    chk("mdm1_en", 32'(en_v()), 32'h00);
    chk("mdm1_fl", 32'(fl_v()), 32'h0);
    next_cyc(); MEM_Access = 1'b0; #2;
    chk("mdm2_en", 32'(en_v()), 32'h03);
    next_cyc(); #2;
    chk("mdm3_en", 32'(en_v()), 32'h03);
    next_cyc(); MEM_Access = 1'b1; #2;
    chk("mdm4_hold_en", 32'(en_v()), 32'h00);
    next_cyc(); MEM_Access = 1'b0; #2;
    chk("mdm5_rel_en", 32'(en_v()), 32'h1F);
    next_cyc(); #2;
    chk("mdm6_busy", 32'(MD_Busy), 32'h0);

    // ---- memory wait, 3 cycles ----
    do_reset();
    MEM_Access = 1'b1; MEM_Ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("mw%0d_en", c), 32'(en_v()), 32'h00);
      next_cyc();
    end
    MEM_Ready = 1'b1; #2;
    chk("mw_rel_en", 32'(en_v()), 32'h1F);
    next_cyc(); idle(); #2;
    chk("mw_stallcnt", 32'(StallCount), 32'd3);
    chk("mw_timeout", 32'(MEM_Timeout), 32'h0);

    // ---- memory timeout (5), then release together with a load-use ----
    do_reset();
    MEM_Access = 1'b1; MEM_Ready = 1'b0;
    for (int c = 0; c < 5; c++) next_cyc();
    #2;
    chk("to5_flag", 32'(MEM_Timeout), 32'h0);
    next_cyc(); #2;
    chk("to6_flag", 32'(MEM_Timeout), 32'h1);
    chk("to6_en", 32'(en_v()), 32'h00);
    next_cyc(); MEM_Ready = 1'b1; set_loaduse(); #2;
    chk("to_rel_lu_en", 32'(en_v()), 32'h07);
    chk("to_rel_lu_fl", 32'(fl_v()), 32'h2);
    next_cyc(); idle(); #2;
    chk("to_sticky", 32'(MEM_Timeout), 32'h1);
    chk("to_run_en", 32'(en_v()), 32'h1F);
    chk("to_stallcnt", 32'(StallCount), 32'd8);

    // ---- reset during MD_BUSY ----
    do_reset();
    EX_MDStart = 1'b1;
    next_cyc(); EX_MDStart = 1'b0;
    next_cyc(); reset = 1'b0; #2;
    chk("rmd_en", 32'(en_v()), 32'h00);
    chk("rmd_fl", 32'(fl_v()), 32'h0);
    chk("rmd_busy", 32'(MD_Busy), 32'h0);
    next_cyc(); reset = 1'b1; #2;
    chk("rmd_after_en", 32'(en_v()), 32'h1F);
    chk("rmd_after_busy", 32'(MD_Busy), 32'h0);
    chk("rmd_after_cnt", 32'(StallCount), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
